// File: rtl/led_ctrl_pkg.sv
// Shared constants, opcodes and FSM encoding for the LED command link.
package led_ctrl_pkg;

    localparam int INSTR_W  = 3;
    localparam int ADDR_W   = 5;
    localparam int FRAME_W  = INSTR_W + ADDR_W;
    localparam int NUM_LEDS = 23;

    localparam logic [INSTR_W-1:0] OP_OFF  = 3'd0;
    localparam logic [INSTR_W-1:0] OP_ON   = 3'd1;
    localparam logic [INSTR_W-1:0] OP_PAT1 = 3'd2;
    localparam logic [INSTR_W-1:0] OP_PAT2 = 3'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_LATCH,
        ST_GAP
    } tx_state_t;

endpackage

// File: rtl/led_tx_tick.sv
// Phase counter: counts 0..CLK_DIV-1, o_phase_done on the last count.
module led_tx_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    output logic o_phase_done
);

    localparam int CW = 8;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_cnt;

    assign o_phase_done = (r_cnt == LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (o_phase_done) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/led_cmd_tx.sv
// 3-wire LED command serializer (clock, data, latch), MSB first.
// Define LED_TX_ADDR_CHECK_EN to drop commands with out-of-range addresses.
module led_cmd_tx #(
    parameter int CLK_DIV  = 4,
    parameter int FRAME_W  = led_ctrl_pkg::FRAME_W,
    parameter int NUM_LEDS = led_ctrl_pkg::NUM_LEDS
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_instr,
    input  logic [4:0] cmd_addr,
    output logic       LED_CLK,
    output logic       LED_DATA,
    output logic       LED_LATCH,
    output logic       busy,
    output logic       err_addr
);

    import led_ctrl_pkg::*;

    if (CLK_DIV < 1 || CLK_DIV > 255) begin : g_bad_div
        $error("led_cmd_tx: CLK_DIV out of range");
    end
    if (FRAME_W != INSTR_W + ADDR_W) begin : g_bad_frame
        $error("led_cmd_tx: FRAME_W must equal INSTR_W+ADDR_W");
    end
    if (NUM_LEDS < 1 || NUM_LEDS > 32) begin : g_bad_leds
        $error("led_cmd_tx: NUM_LEDS out of range");
    end

    localparam logic [2:0] LAST_BIT = 3'(FRAME_W - 1);

    tx_state_t            r_state;
    tx_state_t            w_next;
    logic [FRAME_W-1:0]   r_shreg;
    logic [FRAME_W-1:0]   w_shreg_nxt;
    logic [2:0]           r_bit;
    logic [2:0]           w_bit_nxt;
    logic                 r_clk;
    logic                 r_data;
    logic                 r_latch;
    logic                 r_busy;
    logic                 r_err;
    logic                 w_done;
    logic                 w_accept;
    logic                 w_reject;

    assign cmd_ready = (r_state == ST_IDLE) & ~RESET;
    assign w_accept  = cmd_valid & cmd_ready;

`ifdef LED_TX_ADDR_CHECK_EN
    assign w_reject = ({1'b0, cmd_addr} >= 6'(NUM_LEDS));
`else
    assign w_reject = 1'b0;
`endif

    led_tx_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .i_clk       (CLK),
        .i_rst       (RESET),
        .i_clr       (r_state == ST_IDLE),
        .o_phase_done(w_done)
    );

    always_comb begin
        w_next      = r_state;
        w_shreg_nxt = r_shreg;
        w_bit_nxt   = r_bit;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept && !w_reject) begin
                    w_next      = ST_SHIFT_LO;
                    w_shreg_nxt = {cmd_instr, cmd_addr};
                    w_bit_nxt   = 3'd0;
                end
            end
            ST_SHIFT_LO: begin
                if (w_done) w_next = ST_SHIFT_HI;
            end
            ST_SHIFT_HI: begin
                if (w_done) begin
                    w_shreg_nxt = {r_shreg[FRAME_W-2:0], 1'b0};
                    w_bit_nxt   = r_bit + 3'd1;
                    w_next      = (r_bit == LAST_BIT) ? ST_LATCH
                                                      : ST_SHIFT_LO;
                end
            end
            ST_LATCH: begin
                if (w_done) w_next = ST_GAP;
            end
            ST_GAP: begin
                if (w_done) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they align with it.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= ST_IDLE;
            r_shreg <= '0;
            r_bit   <= '0;
            r_clk   <= 1'b0;
            r_data  <= 1'b0;
            r_latch <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_shreg <= w_shreg_nxt;
            r_bit   <= w_bit_nxt;
            r_clk   <= (w_next == ST_SHIFT_HI);
            r_data  <= ((w_next == ST_SHIFT_LO) || (w_next == ST_SHIFT_HI))
                       & w_shreg_nxt[FRAME_W-1];
            r_latch <= (w_next == ST_LATCH);
            r_busy  <= (w_next != ST_IDLE);
            r_err   <= w_accept & w_reject;
        end
    end

    assign LED_CLK   = r_clk;
    assign LED_DATA  = r_data;
    assign LED_LATCH = r_latch;
    assign busy      = r_busy;
    assign err_addr  = r_err;

endmodule

// File: tb/tb_led_cmd_tx.sv
// Directed bench for led_cmd_tx at CLK_DIV=4 and CLK_DIV=1.
module tb_led_cmd_tx;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       valid = 1'b0;
    logic [2:0] instr = 3'd0;
    logic [4:0] addr = 5'd0;
    logic       sel = 1'b0;

    logic rdy4, lclk4, ldat4, llat4, busy4, err4;
    logic rdy1, lclk1, ldat1, llat1, busy1, err1;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    led_cmd_tx #(.CLK_DIV(4)) u4 (
        .CLK(CLK), .RESET(RESET), .cmd_valid(valid & ~sel),
        .cmd_ready(rdy4), .cmd_instr(instr), .cmd_addr(addr),
        .LED_CLK(lclk4), .LED_DATA(ldat4), .LED_LATCH(llat4),
        .busy(busy4), .err_addr(err4)
    );

    led_cmd_tx #(.CLK_DIV(1)) u1 (
        .CLK(CLK), .RESET(RESET), .cmd_valid(valid & sel),
        .cmd_ready(rdy1), .cmd_instr(instr), .cmd_addr(addr),
        .LED_CLK(lclk1), .LED_DATA(ldat1), .LED_LATCH(llat1),
        .busy(busy1), .err_addr(err1)
    );

    wire w_rdy  = sel ? rdy1  : rdy4;
    wire w_clk  = sel ? lclk1 : lclk4;
    wire w_dat  = sel ? ldat1 : ldat4;
    wire w_lat  = sel ? llat1 : llat4;
    wire w_busy = sel ? busy1 : busy4;
    wire w_err  = sel ? err1  : err4;

    // Receiver model plus protocol checker on the selected link.
    logic       pclk = 1'b0;
    logic       pdat = 1'b0;
    logic       plat = 1'b0;
    logic [7:0] rx = 8'h00;
    logic [7:0] last_word = 8'h00;
    int         latch_cnt = 0;

    always @(negedge CLK) begin
        assert (!(pclk && w_clk && (w_dat !== pdat))) else begin
            errors++;
            $error("FAIL proto_data: DATA %0b->%0b while LED_CLK high",
                   pdat, w_dat);
        end
        assert (!(w_lat && w_clk)) else begin
            errors++;
            $error("FAIL proto_latch: LATCH=%0b with LED_CLK=%0b, need not both",
                   w_lat, w_clk);
        end
        if (!pclk && w_clk) rx = {rx[6:0], w_dat};
        if (w_lat && !plat) begin
            latch_cnt++;
            last_word = rx;
        end
        pclk = w_clk;
        pdat = w_dat;
        plat = w_lat;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)",
                   tag, obs, obs, exp, exp);
        end
    endtask

    // Entered on the negedge where cmd is driven with valid=1.
    task automatic run(input logic [7:0] cmd, input logic [7:0] nxt,
                       input bit hold, input int e_rdy, input int e_ls,
                       input int e_ll, input int e_hi, input string tag);
        int t, ls, ll, hi, lc0, errs;
        chk({tag, "_accept"}, int'(w_rdy), 1);
        lc0 = latch_cnt;
        t = 0; ls = -1; ll = 0; hi = 0; errs = 0;
        do begin
            @(negedge CLK);
            t++;
            if (t == 1) begin
                if (hold) {instr, addr} = nxt;
                else valid = 1'b0;
                chk({tag, "_busy1"}, int'(w_busy), 1);
                chk({tag, "_clk1"}, int'(w_clk), 0);
                chk({tag, "_msb1"}, int'(w_dat), int'(cmd[7]));
            end
            if (w_lat) begin
                if (ls < 0) ls = t;
                ll++;
            end
            if (w_clk) hi++;
            if (w_err) errs++;
        end while (!w_rdy && t < 400);
        chk({tag, "_ready_at"}, t, e_rdy);
        chk({tag, "_latch_at"}, ls, e_ls);
        chk({tag, "_latch_len"}, ll, e_ll);
        chk({tag, "_hi_cycles"}, hi, e_hi);
        chk({tag, "_latch_cnt"}, latch_cnt, lc0 + 1);
        chk({tag, "_word"}, int'(last_word), int'(cmd));
        chk({tag, "_err"}, errs, 0);
        chk({tag, "_busy_end"}, int'(w_busy), 0);
    endtask

    int lc;

    initial begin
        // Reset state
        repeat (3) @(negedge CLK);
        chk("rst_ready", int'(w_rdy), 0);
        chk("rst_clk", int'(w_clk), 0);
        chk("rst_data", int'(w_dat), 0);
        chk("rst_latch", int'(w_lat), 0);
        chk("rst_busy", int'(w_busy), 0);
        chk("rst_err", int'(w_err), 0);
        RESET = 1'b0;
        @(negedge CLK);
        chk("post_rst_ready", int'(w_rdy), 1);

        // ON, addr 5 -> 0x25
        @(negedge CLK);
        valid = 1'b1; {instr, addr} = 8'h25;
        run(8'h25, 8'h00, 1'b0, 73, 65, 4, 32, "t1");

        // Back-to-back with valid held
        @(negedge CLK);
        valid = 1'b1; {instr, addr} = 8'h3F;
        run(8'h3F, 8'hA0, 1'b1, 73, 65, 4, 32, "t2a");
        run(8'hA0, 8'h00, 1'b0, 73, 65, 4, 32, "t2b");

        // Reset during bit 3
        @(negedge CLK);
        valid = 1'b1; {instr, addr} = 8'h25;
        chk("t3_accept", int'(w_rdy), 1);
        lc = latch_cnt;
        @(negedge CLK);
        valid = 1'b0;
        repeat (25) @(negedge CLK);
        chk("t3_mid_busy", int'(w_busy), 1);
        RESET = 1'b1;
        @(negedge CLK);
        chk("t3_clk", int'(w_clk), 0);
        chk("t3_data", int'(w_dat), 0);
        chk("t3_latch", int'(w_lat), 0);
        chk("t3_busy", int'(w_busy), 0);
        chk("t3_ready_rst", int'(w_rdy), 0);
        RESET = 1'b0;
        @(negedge CLK);
        chk("t3_ready", int'(w_rdy), 1);
        repeat (80) @(negedge CLK);
        chk("t3_no_latch", latch_cnt, lc);
        valid = 1'b1; {instr, addr} = 8'hC3;
        run(8'hC3, 8'h00, 1'b0, 73, 65, 4, 32, "t3b");

        // CLK_DIV=1
        @(negedge CLK);
        sel = 1'b1;
        @(negedge CLK);
        valid = 1'b1; {instr, addr} = 8'hFF;
        run(8'hFF, 8'h00, 1'b0, 19, 17, 1, 8, "t4");
        @(negedge CLK);
        sel = 1'b0;

        // Address 23, then 22
        @(negedge CLK);
        valid = 1'b1; {instr, addr} = {3'd1, 5'd23};
`ifdef LED_TX_ADDR_CHECK_EN
        chk("t5_accept", int'(w_rdy), 1);
        lc = latch_cnt;
        @(negedge CLK);
        valid = 1'b0;
        chk("t5_err", int'(w_err), 1);
        chk("t5_ready", int'(w_rdy), 1);
        chk("t5_busy", int'(w_busy), 0);
        chk("t5_clk", int'(w_clk), 0);
        repeat (10) @(negedge CLK);
        chk("t5_err_off", int'(w_err), 0);
        chk("t5_no_latch", latch_cnt, lc);
`else
        run({3'd1, 5'd23}, 8'h00, 1'b0, 73, 65, 4, 32, "t5_23");
`endif
        @(negedge CLK);
        valid = 1'b1; {instr, addr} = {3'd1, 5'd22};
        run({3'd1, 5'd22}, 8'h00, 1'b0, 73, 65, 4, 32, "t5_22");

        repeat (5) @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
